// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the data-memory path: word/byte widths, memory size,
// load/store op-field encodings and the access-unit FSM state type.
package mem_access_unit_pkg;

  localparam int WORD     = 32;
  localparam int BYTE     = 8;
  localparam int MEM_SIZE = 256;
  localparam int FACTOR   = 4;

  // req_op = {store, unsigned, size[1:0]}
  localparam logic [1:0] MEM_SZ_B   = 2'b00;
  localparam logic [1:0] MEM_SZ_H   = 2'b01;
  localparam logic [1:0] MEM_SZ_W   = 2'b10;
  localparam logic [1:0] MEM_SZ_RSV = 2'b11;
  localparam int MEM_OP_STORE_BIT    = 3;
  localparam int MEM_OP_UNSIGNED_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } mau_state_e;

  function automatic logic [2:0] mem_sz_bytes(input logic [1:0] sz);
    case (sz)
      MEM_SZ_B: mem_sz_bytes = 3'd1;
      MEM_SZ_H: mem_sz_bytes = 3'd2;
      default:  mem_sz_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian lane logic: extracts and extends a load lane from a memory word,
// and merges a byte/half store lane into a previously read word.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int WORD_W = WORD
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [WORD_W-1:0] store_data_i,
  output logic [WORD_W-1:0] load_data_o,
  output logic [WORD_W-1:0] merged_o
);

  int                sh;
  logic [WORD_W-1:0] lane;
  logic [WORD_W-1:0] mask;

  // Offset 0 is the most significant lane, so the shift shrinks as offset grows.
  always_comb begin
    sh          = 0;
    lane        = word_i;
    mask        = '1;
    load_data_o = word_i;
    case (size_i)
      MEM_SZ_B: begin
        sh          = WORD_W - 8 - 8 * int'(offset_i);
        lane        = word_i >> sh;
        mask        = {{(WORD_W-8){1'b0}}, 8'hFF} << sh;
        load_data_o = {{(WORD_W-8){lane[7] & ~unsigned_i}}, lane[7:0]};
      end
      MEM_SZ_H: begin
        sh          = WORD_W - 16 - 8 * int'(offset_i);
        lane        = word_i >> sh;
        mask        = {{(WORD_W-16){1'b0}}, 16'hFFFF} << sh;
        load_data_o = {{(WORD_W-16){lane[15] & ~unsigned_i}}, lane[15:0]};
      end
      default: begin
        sh          = 0;
        lane        = word_i;
        mask        = '1;
        load_data_o = word_i;
      end
    endcase
    merged_o = (word_i & ~mask) | ((store_data_i << sh) & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-ported data memory: one request at a time,
// lane extraction for loads, read-modify-write for byte/half stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WORD_W    = WORD,
  parameter int MEM_BYTES = MEM_SIZE * FACTOR
) (
  input  logic              clk,
  input  logic              rst,
  // Request: accepted on a cycle with req_valid && req_ready; no other handshake.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_w,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state_o
);

  mau_state_e        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [WORD_W:0]   last_byte;
  logic              req_err;
  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] merged;
  logic [WORD_W-1:0] word_addr;

  assign dbg_state_o = state_q;
  assign word_addr   = {addr_q[WORD_W-1:2], 2'b00};

  // One extra bit so an address near the top of the space cannot wrap past the bound.
  always_comb begin
    last_byte = {1'b0, req_addr} + {{(WORD_W-2){1'b0}}, mem_sz_bytes(req_op[1:0])}
              - (WORD_W+1)'(1);
    req_err   = (req_op[1:0] == MEM_SZ_RSV)
              | ((req_op[1:0] == MEM_SZ_H) & req_addr[0])
              | ((req_op[1:0] == MEM_SZ_W) & (req_addr[1:0] != 2'b00))
              | (last_byte >= (WORD_W+1)'(MEM_BYTES));
  end

  mem_lane_align #(.WORD_W(WORD_W)) u_align (
    .word_i       (mem_rdata),
    .offset_i     (addr_q[1:0]),
    .size_i       (op_q[1:0]),
    .unsigned_i   (op_q[MEM_OP_UNSIGNED_BIT]),
    .store_data_i (wdata_q),
    .load_data_o  (load_data),
    .merged_o     (merged)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_w      = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          data_d  = '0;
          if (req_err)                         state_d = ST_RESP;
          else if (!req_op[MEM_OP_STORE_BIT])  state_d = ST_LOAD;
          else if (req_op[1:0] == MEM_SZ_W)    state_d = ST_WRITE;
          else                                 state_d = ST_READ;
        end
      end
      ST_LOAD: begin
        mem_addr = word_addr;
        data_d   = load_data;
        state_d  = ST_RESP;
      end
      ST_READ: begin
        mem_addr = word_addr;
        data_d   = merged;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        // Masked in a reset cycle so an interrupted store never reaches memory.
        mem_w     = !rst;
        mem_addr  = word_addr;
        mem_wdata = (op_q[1:0] == MEM_SZ_W) ? wdata_q : data_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (!err_q && !op_q[MEM_OP_STORE_BIT]) ? data_q : '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-array memory, byte-level big-endian reference
// model, directed vectors, held-valid back-to-back traffic and random requests.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int MEM_BYTES = MEM_SIZE * FACTOR;
  localparam int MEM_WORDS = MEM_BYTES / 4;
  localparam int AW        = $clog2(MEM_BYTES);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_w;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  logic [31:0] mem_arr [0:MEM_WORDS-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic        mem_init;
  int          wr_cnt = 0;
  logic [31:0] last_waddr = '0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  mem_access_unit #(.WORD_W(32), .MEM_BYTES(MEM_BYTES)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_w       (mem_w),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / memory environment ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int w);
    seed_word = (32'(w) * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  assign mem_rdata = mem_arr[mem_addr[AW-1:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < MEM_WORDS; w++) mem_arr[w] <= seed_word(w);
    end else if (mem_w) begin
      mem_arr[mem_addr[AW-1:2]] <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte-addressed, big-endian) ----------------
  task automatic model_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, output logic e_err,
                              output logic [31:0] e_rd);
    int n;
    longint a;
    logic [31:0] v;
    logic [31:0] t;
    n = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    a = longint'(addr);
    e_err = (op[1:0] == 2'd3) || (a % n != 0) || (a + n - 1 >= MEM_BYTES);
    e_rd  = '0;
    if (e_err) return;
    if (op[3]) begin
      for (int i = 0; i < n; i++) begin
        t = wd >> (8 * (n - 1 - i));
        ref_mem[int'(a) + i] = t[7:0];
      end
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, ref_mem[int'(a) + i]};
      if (!op[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
      e_rd = v;
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    ref_word = {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};
  endfunction

  // ---------------- driver ----------------
  task automatic run_req(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_wr;
    int          lat;
    int          w0;
    int          waits;
    model_access(op, addr, wd, e_err, e_rd);
    exp_q.push_back(e_rd);
    exp_err_q.push_back(e_err);
    e_lat = e_err ? 1 : (!op[3] ? 2 : (op[1:0] == MEM_SZ_W ? 2 : 3));
    e_wr  = (!e_err && op[3]) ? 1 : 0;
    @(negedge clk);
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = $urandom_range(0, 15);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = resp_rdata;
    if (!resp_valid) check({tag, "_resp_timeout"}, 32'd0, 32'd1);
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err_q.pop_front()});
    check({tag, "_rdata"}, resp_rdata, exp_q.pop_front());
    check({tag, "_writes"}, wr_cnt - w0, e_wr);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] got;
  logic [3:0]  b2b_op   [3];
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_wd   [3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int idx;
    int nresp;
    int bad;
    logic        e_err;
    logic [31:0] e_rd;
    logic [3:0]  r_op;
    logic [31:0] r_addr;

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    for (int w = 0; w < MEM_WORDS; w++)
      for (int k = 0; k < 4; k++) begin
        e_rd = seed_word(w) >> (24 - 8 * k);
        ref_mem[4*w+k] = e_rd[7:0];
      end
    repeat (3) @(negedge clk);
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err",   {31'd0, resp_err},   32'd0);
    check("rst_mem_w",      {31'd0, mem_w},      32'd0);
    check("rst_mem_addr",   mem_addr, 32'd0);
    check("rst_mem_wdata",  mem_wdata, 32'd0);
    mem_init = 1'b0;
    rst = 1'b0;

    // Directed vectors from the bring-up plan.
    run_req("sw8", 4'b1010, 32'd8, 32'h11223344, got);
    check("sw8_waddr", last_waddr, 32'd8);
    run_req("lb9", 4'b0000, 32'd9, 32'h0, got);
    check("lb9_value", got, 32'h00000022);
    run_req("lbu11", 4'b0100, 32'd11, 32'h0, got);
    check("lbu11_value", got, 32'h00000044);
    run_req("lw8", 4'b0010, 32'd8, 32'h0, got);
    check("lw8_value", got, 32'h11223344);
    run_req("sb10", 4'b1000, 32'd10, 32'h000000AB, got);
    check("sb10_mem", mem_arr[2], 32'h1122AB44);
    run_req("lh10", 4'b0001, 32'd10, 32'h0, got);
    check("lh10_value", got, 32'hFFFFAB44);
    run_req("lhu10", 4'b0101, 32'd10, 32'h0, got);
    check("lhu10_value", got, 32'h0000AB44);

    run_req("err_lw6",   4'b0010, 32'd6, 32'h0, got);
    run_req("err_sh9",   4'b1001, 32'd9, 32'h0000BEEF, got);
    run_req("err_sz11",  4'b0011, 32'd4, 32'h0, got);
    run_req("err_sw_oob", 4'b1010, 32'(MEM_BYTES - 2), 32'hDEADBEEF, got);
    run_req("err_lw_top", 4'b0010, 32'(MEM_BYTES), 32'h0, got);

    // Half store interrupted by reset in its READ cycle.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1001; req_addr = 32'd8; req_wdata = 32'h0000BEEF;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstrd_busy", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_idle", {31'd0, req_ready}, 32'd1);
    check("rstrd_mem_w", {31'd0, mem_w}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstrd_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    check("rstrd_writes", wr_cnt - w0, 32'd0);
    check("rstrd_mem", mem_arr[2], 32'h1122AB44);

    // Three requests with req_valid held high throughout.
    b2b_op[0] = 4'b1010; b2b_addr[0] = 32'd16; b2b_wd[0] = $urandom;
    b2b_op[1] = 4'b0001; b2b_addr[1] = 32'd18; b2b_wd[1] = $urandom;
    b2b_op[2] = 4'b0100; b2b_addr[2] = 32'd19; b2b_wd[2] = $urandom;
    idx = 0; nresp = 0;
    for (int cyc = 0; cyc < 60 && nresp < 3; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) check("b2b_extra_resp", 32'd1, 32'd0);
        else begin
          check("b2b_rdata", resp_rdata, exp_q.pop_front());
          check("b2b_err", {31'd0, resp_err}, {31'd0, exp_err_q.pop_front()});
        end
        nresp++;
      end
      if (idx < 3) begin
        req_valid = 1'b1;
        req_op    = b2b_op[idx];
        req_addr  = b2b_addr[idx];
        req_wdata = b2b_wd[idx];
        if (req_ready) begin
          model_access(b2b_op[idx], b2b_addr[idx], b2b_wd[idx], e_err, e_rd);
          exp_q.push_back(e_rd);
          exp_err_q.push_back(e_err);
          idx++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_resp_count", nresp, 32'd3);
    check("b2b_queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_err_q.delete();

    // Random traffic, biased toward a small window so loads see earlier stores.
    for (int n = 0; n < 60; n++) begin
      r_op = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) r_addr = $urandom_range(0, 31);
      else r_addr = $urandom_range(0, MEM_BYTES + 7);
      if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~((r_op[1:0] == 2'd0) ? 32'd0 :
                                                      (r_op[1:0] == 2'd1) ? 32'd1 : 32'd3);
      run_req("rnd", r_op, r_addr, $urandom, got);
    end

    @(negedge clk);
    bad = 0;
    for (int w = 0; w < MEM_WORDS; w++) if (mem_arr[w] !== ref_word(w)) bad++;
    check("mem_image_bad_words", bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
